// File: rtl/data_mem_access.sv
// MEM-stage load/store controller driving an asynchronous SRAM over a shared tri-state bus.
// Read: 1 setup + WAIT_CYCLES strobe cycles then DONE; write adds a 1-cycle data hold; mem_stall freezes the pipeline until DONE.
module data_mem_access #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  inout  wire  [15:0]       ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [15:0]       Ramdata,
  output logic              mem_stall,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] ramdata_q;
  logic        en_q, oe_q, we_q, drive_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'd0;
      wdata_q   <= 16'd0;
      ramdata_q <= 16'd0;
      en_q      <= 1'b1;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      drive_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // Store wins when both requests are raised together.
          if (mem_write) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            en_q    <= 1'b0;
            drive_q <= 1'b1;
            state_q <= WR_SETUP;
          end else if (mem_read) begin
            addr_q  <= addr;
            en_q    <= 1'b0;
            oe_q    <= 1'b0;
            state_q <= RD_SETUP;
          end
        end
        RD_SETUP: begin
          cnt_q   <= 4'd0;
          state_q <= RD_STROBE;
        end
        RD_STROBE: begin
          if (cnt_q == LAST) begin
            ramdata_q <= ram_data;
            en_q      <= 1'b1;
            oe_q      <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        WR_SETUP: begin
          we_q    <= 1'b0;
          cnt_q   <= 4'd0;
          state_q <= WR_STROBE;
        end
        WR_STROBE: begin
          if (cnt_q == LAST) begin
            we_q    <= 1'b1;
            state_q <= WR_HOLD;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        WR_HOLD: begin
          en_q    <= 1'b1;
          drive_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // In IDLE the stall must rise in the same cycle the request appears.
  assign mem_stall = !rst && ((state_q == IDLE) ? (mem_read | mem_write)
                                                : (state_q != DONE));

  assign ram_data = drive_q ? wdata_q : 16'hzzzz;
  assign ram_addr = {{(ADDR_W-16){1'b0}}, addr_q};
  assign ram_en   = en_q;
  assign ram_oe   = oe_q;
  assign ram_we   = we_q;
  assign Ramdata  = ramdata_q;
  assign done     = done_q;

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- MEM-stage controller between pipeline and external asynchronous SRAM (data RAM); sits directly upstream of the writeback data mux.
- Converts one-cycle load/store requests into multi-cycle SRAM strobe sequences on a shared bidirectional bus.
- Returns load data on Ramdata and stalls the pipeline via mem_stall until the access completes.

Parameters:
- WAIT_CYCLES, 2, cycles the read/write strobe is held active; legal range 1..15.
- ADDR_W, 18, width of external SRAM address bus; upper bits zero-extended from the 16-bit CPU address.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  load request from MEM stage, held stable while mem_stall=1
- mem_write  input  1  store request from MEM stage, held stable while mem_stall=1
- addr  input  16  word address of access
- wdata  input  16  store data
- ram_data  inout  16  SRAM data bus; driven only during write phases, else high-Z
- ram_addr  output  ADDR_W  SRAM address = {zeros, latched addr}
- ram_en  output  1  SRAM chip enable, active low
- ram_oe  output  1  SRAM output enable, active low
- ram_we  output  1  SRAM write enable, active low
- Ramdata  output  16  last loaded word, consumed by writeback mux
- mem_stall  output  1  freeze upstream pipeline stages
- done  output  1  one-cycle pulse on access completion

Behaviour:
- One clock, reset synchronous and active-high: at rst=1 on a rising edge → state IDLE, ram_en=ram_oe=ram_we=1, ram_addr=0, Ramdata=0, done=0, counter=0, ram_data high-Z. Applies mid-access; no partial write completes (ram_we deasserted on that edge). mem_stall=0 while rst=1.
- States: IDLE, RD_SETUP, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, DONE.
- IDLE: mem_stall combinationally = mem_read|mem_write. On request, latch addr/wdata; mem_write has priority if both asserted (→ write only). Read → RD_SETUP; write → WR_SETUP.
- RD_SETUP (1 cycle): ram_addr valid, ram_en=0, ram_oe=0, ram_we=1. → RD_STROBE, counter=0.
- RD_STROBE (WAIT_CYCLES cycles): ram_en=0, ram_oe=0. On final cycle, capture ram_data into Ramdata at the clock edge. → DONE.
- WR_SETUP (1 cycle): ram_addr and ram_data driven, ram_en=0, ram_we=1, ram_oe=1. → WR_STROBE.
- WR_STROBE (WAIT_CYCLES cycles): ram_we=0, bus driven.
- WR_HOLD (1 cycle): ram_we=1, bus and address still driven (data hold). → DONE.
- DONE (1 cycle): strobes inactive, bus high-Z, done=1, mem_stall=0. Requests are ignored here (same instruction still present). → IDLE.
- Ramdata changes only on read capture or reset; stores leave it unchanged.
- Bus never driven while ram_oe=0 (no contention). ram_oe and ram_we are never both 0.
- Latency (request seen in IDLE at cycle 0):
  - Read: Ramdata valid from cycle 2+WAIT_CYCLES (DONE); mem_stall high cycles 0..1+WAIT_CYCLES.
  - Write: DONE at cycle 3+WAIT_CYCLES; mem_stall high cycles 0..2+WAIT_CYCLES.
- Back-to-back: a new request in the cycle after DONE starts immediately from IDLE.
- Counter is 4 bits and resets on entry to each STROBE state.

Test Plan:
- Reset values: rst=1 for 2 cycles → ram_en/oe/we=1, Ramdata=0x0000, mem_stall=0, done=0, ram_data=Z.
- Read, WAIT_CYCLES=2: SRAM model holds 0xBEEF at 0x0123; mem_read=1, addr=0x0123 → ram_addr=0x00123; oe low cycles 1..3; Ramdata=0xBEEF at cycle 4; done pulse at cycle 4; mem_stall high cycles 0..3.
- Write then read: mem_write=1, addr=0x0040, wdata=0x5A5A → we low exactly 2 cycles, data driven cycles 1..4, done at cycle 5, Ramdata unchanged. Next mem_read at 0x0040 → Ramdata=0x5A5A.
- Simultaneous mem_read=mem_write=1, addr=0x0010, wdata=0x1234 → write sequence only, oe never low, memory[0x10]=0x1234.
- Reset mid-write: rst=1 in the first WR_STROBE cycle → next edge ram_we=1, bus=Z, state IDLE, mem_stall=0.
- WAIT_CYCLES=1 and 15: read latency 3 and 17 cycles respectively; back-to-back reads at 0x0000 (0x1111) and 0x0001 (0x2222) → Ramdata 0x1111 then 0x2222, with one IDLE gap cycle at most.
